// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the CPU/debug memory arbiter.
package mem_arb_pkg;

  // State names the owner of the most recent transfer.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    DBG_OWN  = 2'd2,
    DBG_LOCK = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int MAX_BURST_W = 4;

  // Burst counter increment that sticks at the limit.
  function automatic logic [MAX_BURST_W-1:0] sat_inc(
    input logic [MAX_BURST_W-1:0] cnt,
    input logic [MAX_BURST_W-1:0] lim
  );
    return (cnt >= lim) ? lim : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/rd_resp_reg.sv
// Per-port registered read response: one-cycle rvalid pulse, sticky rdata.
module rd_resp_reg #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cap_i,
  input  logic [DW-1:0] rd_i,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o
);

  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  // Capture memory data on a read transfer; rdata holds until the next read.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cap_i;
      if (cap_i) rdata_q <= rd_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU core, debug/loader) onto a single unified memory.
// One access per cycle, bounded bursts for fairness, debug lock for loading.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int CPU_PRIO  = 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  // CPU port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  // debug port
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wd,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          arb_locked
);

  localparam logic [MAX_BURST_W-1:0] MAX_B = MAX_BURST_W'(MAX_BURST);

  arb_state_t             state_q;
  logic [MAX_BURST_W-1:0] burst_cnt_q;
  logic                   locked_q;
  owner_t                 win;

  // Grant decision from registered state/count and live requests.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    win     = OWN_CPU;
    if (RSTn) begin
      if (state_q == DBG_LOCK) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        case (state_q)
          IDLE:    win = (CPU_PRIO != 0) ? OWN_CPU : OWN_DBG;
          CPU_OWN: win = (burst_cnt_q < MAX_B) ? OWN_CPU : OWN_DBG;
          DBG_OWN: win = (burst_cnt_q < MAX_B) ? OWN_DBG : OWN_CPU;
          default: win = OWN_CPU;
        endcase
        cpu_gnt = (win == OWN_CPU);
        dbg_gnt = (win == OWN_DBG);
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  // Memory mux: granted port drives the bus, zeros when nobody is granted.
  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
      mem_we   = cpu_we;
    end else if (dbg_gnt) begin
      mem_addr = dbg_addr;
      mem_wd   = dbg_wd;
      mem_we   = dbg_we;
    end
  end

  // Ownership FSM with burst counter and registered lock flag.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      locked_q    <= 1'b0;
    end else begin
      case (state_q)
        DBG_LOCK: begin
          // Lock is held purely by dbg_lock; MAX_BURST plays no part here.
          if (!dbg_lock) begin
            locked_q <= 1'b0;
            if (dbg_gnt) begin
              state_q     <= DBG_OWN;
              burst_cnt_q <= MAX_BURST_W'(1);
            end else begin
              state_q     <= IDLE;
              burst_cnt_q <= '0;
            end
          end
        end
        default: begin
          if (dbg_gnt && dbg_lock) begin
            state_q     <= DBG_LOCK;
            burst_cnt_q <= MAX_BURST_W'(1);
            locked_q    <= 1'b1;
          end else if (cpu_gnt) begin
            state_q     <= CPU_OWN;
            burst_cnt_q <= (state_q == CPU_OWN) ? sat_inc(burst_cnt_q, MAX_B)
                                                : MAX_BURST_W'(1);
          end else if (dbg_gnt) begin
            state_q     <= DBG_OWN;
            burst_cnt_q <= (state_q == DBG_OWN) ? sat_inc(burst_cnt_q, MAX_B)
                                                : MAX_BURST_W'(1);
          end else begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign arb_locked = locked_q;

  rd_resp_reg #(.DW(DW)) u_cpu_resp (
    .clk_i    (CLK),
    .rst_n_i  (RSTn),
    .cap_i    (cpu_gnt & ~cpu_we),
    .rd_i     (mem_rd),
    .rvalid_o (cpu_rvalid),
    .rdata_o  (cpu_rdata)
  );

  rd_resp_reg #(.DW(DW)) u_dbg_resp (
    .clk_i    (CLK),
    .rst_n_i  (RSTn),
    .cap_i    (dbg_gnt & ~dbg_we),
    .rd_i     (mem_rd),
    .rvalid_o (dbg_rvalid),
    .rdata_o  (dbg_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random run
// against a grant-history reference model and a simple word memory.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wd;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          arb_locked;

  logic [DW-1:0] memw [0:63];
  assign mem_rd = memw[mem_addr[7:2]];

  always #5 CLK = ~CLK;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .CPU_PRIO(1)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .arb_locked(arb_locked)
  );

  int tests_run = 0;
  int fails     = 0;

  // Reference model: log of who got each transfer (0 none / run break,
  // 1 cpu, 2 dbg), a lock flag, and expected response registers.
  int            glog[$];
  bit            m_locked;
  logic          e_cg, e_dg, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic          e_cpu_rv, e_dbg_rv;
  logic [DW-1:0] e_cpu_rd, e_dbg_rd, nxt_cpu_rd, nxt_dbg_rd;

  // Expected grants/bus for the current inputs, then let comb logic settle.
  task automatic settle();
    int last, run;
    e_cg = 1'b0;
    e_dg = 1'b0;
    if (RSTn) begin
      if (m_locked) e_dg = dbg_req;
      else if (cpu_req && dbg_req) begin
        last = (glog.size() > 0) ? glog[glog.size()-1] : 0;
        if (last == 0) e_cg = 1'b1;
        else begin
          run = 0;
          for (int i = glog.size()-1; i >= 0; i--) begin
            if (glog[i] != last || run >= MAXB) break;
            run++;
          end
          if ((run < MAXB) == (last == 1)) e_cg = 1'b1; else e_dg = 1'b1;
        end
      end else begin
        e_cg = cpu_req;
        e_dg = dbg_req;
      end
    end
    e_addr = e_cg ? cpu_addr : (e_dg ? dbg_addr : '0);
    e_wd   = e_cg ? cpu_wd   : (e_dg ? dbg_wd   : '0);
    e_we   = e_cg ? cpu_we   : (e_dg ? dbg_we   : 1'b0);
    nxt_cpu_rd = memw[cpu_addr[7:2]];
    nxt_dbg_rd = memw[dbg_addr[7:2]];
    #3;
  endtask

  // Clock edge: memory takes the DUT's write, model takes the expected transfer.
  task automatic advance();
    logic          dwe;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    int own;
    dwe = mem_we; da = mem_addr; dd = mem_wd;
    @(posedge CLK);
    if (!RSTn) begin
      m_locked = 0;
      glog.push_back(0);
      e_cpu_rv = 0; e_dbg_rv = 0; e_cpu_rd = '0; e_dbg_rd = '0;
    end else begin
      own = e_cg ? 1 : (e_dg ? 2 : 0);
      e_cpu_rv = e_cg && !cpu_we;
      e_dbg_rv = e_dg && !dbg_we;
      if (e_cpu_rv) e_cpu_rd = nxt_cpu_rd;
      if (e_dbg_rv) e_dbg_rd = nxt_dbg_rd;
      if (m_locked) begin
        if (!dbg_lock) begin
          m_locked = 0;
          glog.push_back(0);
          glog.push_back(own);
        end
      end else begin
        if (own == 2 && dbg_lock) m_locked = 1;
        glog.push_back(own);
      end
    end
    if (dwe) memw[da[7:2]] = dd;
    while (glog.size() > 32) void'(glog.pop_front());
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wd = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wd = '0; dbg_lock = 0;
  endtask

  task automatic test_reset();
    RSTn = 0; cpu_req = 1; dbg_req = 1; cpu_addr = 32'h4; dbg_addr = 32'hC;
    settle();
    tests_run++;
    if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      fails++; $display("FAIL reset_gnt: got cpu=%b dbg=%b want 0/0", cpu_gnt, dbg_gnt);
    end
    advance(); settle(); advance(); settle();
    tests_run++;
    if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || cpu_rdata !== '0 || dbg_rdata !== '0 || arb_locked !== 1'b0) begin
      fails++; $display("FAIL reset_regs: got rv=%b/%b rd=%h/%h lk=%b want zeros",
                        cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, arb_locked);
    end
    RSTn = 1;
    settle();
    tests_run++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      fails++; $display("FAIL reset_first_gnt: got cpu=%b dbg=%b want 1/0", cpu_gnt, dbg_gnt);
    end
    advance();
    idle_inputs(); settle(); advance();
  endtask

  task automatic test_read_latency();
    memw[2] = 32'hDEADBEEF;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
    settle();
    tests_run++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8) begin
      fails++; $display("FAIL rd_issue: got gnt=%b we=%b addr=%h want 1/0/00000008", cpu_gnt, mem_we, mem_addr);
    end
    advance();
    cpu_req = 0;
    settle();
    tests_run++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_resp: got rv=%b rd=%h want 1/deadbeef", cpu_rvalid, cpu_rdata);
    end
    advance(); settle();
    tests_run++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_hold: got rv=%b rd=%h want 0/deadbeef", cpu_rvalid, cpu_rdata);
    end
    advance();
  endtask

  task automatic test_fairness();
    logic want_c;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h24;
    for (int i = 0; i < 12; i++) begin
      want_c = (i < 4) || (i >= 8);
      settle();
      tests_run++;
      if (cpu_gnt !== want_c || dbg_gnt !== !want_c || cpu_gnt !== e_cg) begin
        fails++; $display("FAIL fair_%0d: got cpu=%b dbg=%b want %b/%b", i, cpu_gnt, dbg_gnt, want_c, !want_c);
      end
      advance();
    end
    idle_inputs(); settle(); advance();
  endtask

  task automatic test_write_path();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wd = 32'h12345678;
    settle();
    tests_run++;
    if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wd !== 32'h12345678 || mem_addr !== 32'h10) begin
      fails++; $display("FAIL wr_issue: got gnt=%b we=%b wd=%h addr=%h want 1/1/12345678/00000010",
                        dbg_gnt, mem_we, mem_wd, mem_addr);
    end
    advance();
    idle_inputs();
    settle();
    tests_run++;
    if (mem_we !== 1'b0 || dbg_rvalid !== 1'b0 || memw[4] !== 32'h12345678) begin
      fails++; $display("FAIL wr_after: got we=%b rv=%b mem=%h want 0/0/12345678", mem_we, dbg_rvalid, memw[4]);
    end
    advance();
  endtask

  task automatic test_lock();
    logic [AW-1:0] la [3];
    la[0] = 32'h0; la[1] = 32'h4; la[2] = 32'h8;
    dbg_we = 1; dbg_lock = 1;
    for (int i = 0; i < 3; i++) begin
      dbg_req = 1; dbg_addr = la[i]; dbg_wd = 32'hA000_0000 + 32'(i);
      settle();
      tests_run++;
      if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || arb_locked !== (i > 0)) begin
        fails++; $display("FAIL lock_wr_%0d: got dbg=%b cpu=%b lk=%b want 1/0/%b", i, dbg_gnt, cpu_gnt, arb_locked, i > 0);
      end
      advance();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    end
    dbg_req = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      tests_run++;
      if (cpu_gnt !== 1'b0 || arb_locked !== 1'b1) begin
        fails++; $display("FAIL lock_hold_%0d: got cpu=%b lk=%b want 0/1", i, cpu_gnt, arb_locked);
      end
      advance();
    end
    dbg_lock = 0;
    settle();
    tests_run++;
    if (cpu_gnt !== 1'b0 || arb_locked !== 1'b1) begin
      fails++; $display("FAIL lock_exit_edge: got cpu=%b lk=%b want 0/1", cpu_gnt, arb_locked);
    end
    advance(); settle();
    tests_run++;
    if (cpu_gnt !== 1'b1 || arb_locked !== 1'b0) begin
      fails++; $display("FAIL lock_release: got cpu=%b lk=%b want 1/0", cpu_gnt, arb_locked);
    end
    advance();
    idle_inputs(); settle(); advance();
  endtask

  task automatic test_reset_mid_lock();
    dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 32'h30; dbg_wd = 32'h55AA55AA;
    settle(); advance();
    dbg_we = 0;
    settle();
    tests_run++;
    if (arb_locked !== 1'b1 || dbg_gnt !== 1'b1) begin
      fails++; $display("FAIL rml_locked: got lk=%b gnt=%b want 1/1", arb_locked, dbg_gnt);
    end
    advance();
    RSTn = 0;
    settle(); advance();
    RSTn = 1; dbg_req = 0; dbg_lock = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
    settle();
    tests_run++;
    if (arb_locked !== 1'b0 || cpu_gnt !== 1'b1 || dbg_rvalid !== 1'b0 || dbg_rdata !== '0) begin
      fails++; $display("FAIL rml_after: got lk=%b cpu=%b rv=%b rd=%h want 0/1/0/0",
                        arb_locked, cpu_gnt, dbg_rvalid, dbg_rdata);
    end
    advance();
    idle_inputs(); settle(); advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      // a requester keeps its transaction stable until it is granted
      if (!cpu_req || e_cg) begin
        cpu_req  = ($urandom_range(0, 3) != 0);
        cpu_we   = $urandom_range(0, 1);
        cpu_addr = 32'($urandom_range(0, 63)) << 2;
        cpu_wd   = $urandom;
      end
      if (!dbg_req || e_dg) begin
        dbg_req  = ($urandom_range(0, 2) != 0);
        dbg_we   = $urandom_range(0, 1);
        dbg_addr = 32'($urandom_range(0, 63)) << 2;
        dbg_wd   = $urandom;
      end
      if ($urandom_range(0, 9) == 0) dbg_lock = ~dbg_lock;
      settle();
      tests_run++;
      if (cpu_gnt !== e_cg || dbg_gnt !== e_dg) begin
        fails++; $display("FAIL rnd_gnt_%0d: got cpu=%b dbg=%b want %b/%b", n, cpu_gnt, dbg_gnt, e_cg, e_dg);
      end
      tests_run++;
      if (mem_we !== e_we || mem_addr !== e_addr || mem_wd !== e_wd) begin
        fails++; $display("FAIL rnd_bus_%0d: got we=%b a=%h d=%h want %b/%h/%h", n, mem_we, mem_addr, mem_wd, e_we, e_addr, e_wd);
      end
      tests_run++;
      if (cpu_rvalid !== e_cpu_rv || cpu_rdata !== e_cpu_rd || dbg_rvalid !== e_dbg_rv || dbg_rdata !== e_dbg_rd) begin
        fails++; $display("FAIL rnd_resp_%0d: got %b/%h %b/%h want %b/%h %b/%h", n, cpu_rvalid, cpu_rdata,
                          dbg_rvalid, dbg_rdata, e_cpu_rv, e_cpu_rd, e_dbg_rv, e_dbg_rd);
      end
      tests_run++;
      if (arb_locked !== m_locked) begin
        fails++; $display("FAIL rnd_lock_%0d: got %b want %b", n, arb_locked, m_locked);
      end
      advance();
    end
    idle_inputs(); settle(); advance();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) memw[i] = $urandom;
    m_locked = 0;
    e_cpu_rv = 0; e_dbg_rv = 0; e_cpu_rd = '0; e_dbg_rd = '0;
    idle_inputs();
    #1;
    test_reset();
    test_read_latency();
    test_fairness();
    test_write_path();
    test_lock();
    test_reset_mid_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
